// File: rtl/ddr_serializer.sv
// Word-to-bit-pair serializer feeding a DDR output stage: one bit pair per clock,
// MSB first, with data / PRBS7 / toggle / zero sources and underrun reporting.
module ddr_serializer #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hD5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_rise,
  output logic             d_fall,
  output logic             word_start,
  output logic             underrun,
  input  logic             clear_underrun,
  output logic [15:0]      word_count,
  output logic             dbg_state
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = $clog2(PAIRS);
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  localparam logic [1:0] MODE_DATA = 2'b00;
  localparam logic [1:0] MODE_PRBS = 2'b01;
  localparam logic [1:0] MODE_TOG  = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] prbs_word;
  logic [CW-1:0]    cnt;
  logic [6:0]       p;
  logic [6:0]       p_nxt;
  logic [6:0]       prbs_tmp;
  logic             prbs_bit;
  logic             boundary;
  logic             accept;
  logic             set_underrun;

  // Handshake: in_ready is a pure function of mode/cnt/reset and never looks at
  // in_valid; a word transfers on a rising edge where in_valid && in_ready.
  assign boundary  = (cnt == LAST);
  assign in_ready  = (mode == MODE_DATA) && boundary && !reset;
  assign accept    = in_valid && in_ready;

  assign d_rise     = sreg[WIDTH-1];
  assign d_fall     = sreg[WIDTH-2];
  assign word_start = (cnt == '0) && !reset;
  assign dbg_state  = (state == S_RUN);

  // One whole word of PRBS7 (x^7+x^6+1) is unrolled per boundary.
  always_comb begin
    prbs_tmp  = p;
    prbs_bit  = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prbs_bit               = prbs_tmp[6] ^ prbs_tmp[5];
      prbs_tmp               = {prbs_tmp[5:0], prbs_bit};
      prbs_word[WIDTH-1-i]   = prbs_bit;
    end
    p_nxt = prbs_tmp;
  end

  always_comb begin
    load_word = '0;
    case (mode)
      MODE_DATA: load_word = accept ? in_data : IDLE_WORD;
      MODE_PRBS: load_word = prbs_word;
      MODE_TOG:  load_word = {PAIRS{2'b10}};
      default:   load_word = '0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    set_underrun = 1'b0;
    if (boundary) begin
      case (state)
        S_IDLE: if (accept) state_nxt = S_RUN;
        S_RUN: begin
          if (mode != MODE_DATA) state_nxt = S_IDLE;
          else if (!in_valid)    set_underrun = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= LAST;
      p          <= 7'h7F;
      underrun   <= 1'b0;
      word_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (boundary) begin
        sreg       <= load_word;
        cnt        <= '0;
        word_count <= word_count + 16'h0001;
        if (mode == MODE_PRBS) p <= p_nxt;
      end else begin
        sreg <= {sreg[WIDTH-3:0], 2'b00};
        cnt  <= cnt + CW'(1);
      end
      // A new underrun on the same edge as a clear must not be lost.
      if (set_underrun)        underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: doc/ddr_serializer.md
DDR_SERIALIZER -- requirements
Module: ddr_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width; it SHALL be even and >= 4.
REQ-002 SHALL have parameter IDLE_WORD, default 8'hD5, meaning the filler word sent when no data is available.
REQ-003 SHALL have port clk, input, 1 bit: single clock (the DDR bit-pair clock); all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mode, input, 2 bits: 00 data, 01 PRBS7, 10 toggle pattern, 11 all-zero.
REQ-006 SHALL have port in_data, input, WIDTH bits: parallel word, MSB sent first.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_data on this edge.
REQ-009 SHALL have port d_rise, output, 1 bit: the bit for the rising-edge half of the DDR output stage.
REQ-010 SHALL have port d_fall, output, 1 bit: the bit for the falling-edge half of the DDR output stage.
REQ-011 SHALL have port word_start, output, 1 bit: high while the first bit pair of a word is on d_rise/d_fall.
REQ-012 SHALL have port underrun, output, 1 bit: sticky flag, set when an idle word is sent while in RUN.
REQ-013 SHALL have port clear_underrun, input, 1 bit: synchronous clear of underrun.
REQ-014 SHALL have port word_count, output, 16 bits: number of words loaded since reset; it wraps from 16'hFFFF to 0.

Function
REQ-015 SHALL hold a WIDTH-bit shift register sreg and a pair counter cnt running 0..WIDTH/2-1.
REQ-016 SHALL drive d_rise from sreg[WIDTH-1] and d_fall from sreg[WIDTH-2]; both outputs are register-driven with no combinational path from inputs.
REQ-017 SHALL, on each edge where cnt != WIDTH/2-1, shift sreg left by 2 (zero fill) and increment cnt.
REQ-018 SHALL treat an edge where cnt == WIDTH/2-1 as a word boundary: it loads sreg with the next word, sets cnt to 0 and increments word_count.
REQ-019 SHALL assert in_ready only when mode == 00, cnt == WIDTH/2-1 and reset is low; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL source the word loaded at a boundary in mode 00 as follows: in_data if in_valid & in_ready, otherwise IDLE_WORD.
REQ-021 SHALL implement a two-state FSM. IDLE -> RUN on the first accepted word in mode 00. RUN -> IDLE at any boundary where mode != 00. RUN stays RUN otherwise.
REQ-022 SHALL set underrun at a boundary in mode 00, state RUN, with in_valid low; in IDLE no underrun is flagged.
REQ-023 SHALL give set priority over clear_underrun when both occur on the same edge.
REQ-024 SHALL implement mode 01 as PRBS7, polynomial x^7+x^6+1, Fibonacci form, with a 7-bit state p.
REQ-025 SHALL, per generated bit, compute new = p[6]^p[5], then p <= {p[5:0],new}, and emit new.
REQ-026 SHALL generate WIDTH consecutive PRBS bits per boundary, first generated bit in the MSB.
REQ-027 SHALL advance p only at boundaries in mode 01, and p SHALL keep its value while in other modes.
REQ-028 SHALL load a word of repeated 2'b10 at a boundary in mode 10, and all zeros in mode 11.
REQ-029 SHALL sample mode only at boundaries; a mode change mid-word SHALL take effect at the next boundary.
REQ-030 SHALL assert word_start exactly when cnt == 0.

Reset
REQ-031 SHALL, while reset is high, set sreg = 0, cnt = WIDTH/2-1, state = IDLE, p = 7'h7F, underrun = 0 and word_count = 0.
REQ-032 SHALL give d_rise = 0, d_fall = 0, word_start = 0 and in_ready = 0 during reset.
REQ-033 SHALL make the first edge after reset deassertion a boundary.
REQ-034 SHALL discard any partially sent word when reset is asserted mid-word.

Verification (WIDTH=8, IDLE_WORD=8'hD5)
REQ-035 SHALL cover: mode 00, 8'hA5 valid at first boundary -> (d_rise,d_fall) = (1,0),(1,0),(0,1),(0,1) over 4 cycles, word_start high in the first cycle, word_count = 1.
REQ-036 SHALL cover: mode 00, 8'h3C accepted, then in_valid low at the next boundary -> 8'hD5 sent as (1,1),(0,1),(0,1),(0,1), underrun = 1; it stays 1 until clear_underrun, then reads 0.
REQ-037 SHALL cover: mode 00, in_valid low from reset -> 8'hD5 repeats, underrun stays 0, in_ready pulses high 1 cycle in every 4.
REQ-038 SHALL cover: mode 01 from reset -> first word 8'h02, pairs (0,0),(0,0),(0,0),(1,0); the next word continues from p = 7'h02.
REQ-039 SHALL cover: mode switched 00 -> 10 mid-word -> the current word completes, then 1,0 pairs; in_ready stays low; state = IDLE.
REQ-040 SHALL cover: reset asserted at cnt = 1 -> outputs 0 on the next edge; the first boundary on release; word_count = 0.
